alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide. It sits beside the single-cycle ALU in the execute stage. Decode hands it an M-extension request (opcode 0110011, funct7 0000001); the block iterates a shared shift/add-subtract datapath for 32 cycles. It stalls the core until the result is consumed, then returns to idle.

---
 rtl/alu_muldiv_pkg.sv | 36 +++
 rtl/muldiv_datapath.sv | 104 ++++++++++
 rtl/alu_muldiv_seq.sv | 105 ++++++++++
 tb/tb_alu_muldiv_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// Holds the funct3 codes, the FSM state type and the operand magnitude helper.
package alu_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_RTYPE) && (funct7 == F7_MULDIV);
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/add-subtract datapath: operand magnitudes, 64-bit accumulator,
// one radix-2 step per cycle, and the final sign correction / result select.
module muldiv_datapath
  import alu_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  output logic [XLEN-1:0] fix_result
);

  logic [2:0]        op;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;

  logic              a_signed;
  logic              b_signed;
  logic              in_neg_a;
  logic              in_neg_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_t;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  logic              div_zero;
  logic              div_ovf;

  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    in_neg_a = a_signed & rs1[XLEN-1];
    in_neg_b = b_signed & rs2[XLEN-1];
  end

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    div_zero       = funct3[2] && (rs2 == '0);
    div_ovf        = funct3[2] && !funct3[0] &&
                     (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special        = div_zero || div_ovf;
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? rs1 : '1;
    else if (div_ovf)
      special_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};

    div_t    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_t} - {2'b00, opb};
    div_next = div_diff[XLEN+1] ? {div_t[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_fix   = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    quot_fix   = magnitude(acc[XLEN-1:0], neg_a ^ neg_b);
    rem_fix    = magnitude(acc[2*XLEN-1:XLEN], neg_a);
    fix_result = '0;
    case (op)
      F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op    <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      opb   <= '0;
      acc   <= '0;
    end else if (load) begin
      op    <= funct3;
      neg_a <= in_neg_a;
      neg_b <= in_neg_b;
      opb   <= magnitude(rs2, in_neg_b);
      acc   <= {{XLEN{1'b0}}, magnitude(rs1, in_neg_a)};
    end else if (step) begin
      acc   <= op[2] ? div_next : mul_next;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32M multi-cycle sequencer: accepts one M-type op, iterates 32 cycles on the
// shared datapath, and stalls the core until writeback takes the result.
//   state | meaning
//   IDLE  | ready for a request
//   MUL   | 32 shift-add iterations
//   DIV   | 32 restoring-divide iterations
//   FIX   | sign correction and result select
//   DONE  | result_valid held until result_ready
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] muldiv_result,
  output logic            stall
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             special;
  logic [XLEN-1:0]  special_result;
  logic [XLEN-1:0]  fix_result;

  assign load  = (state == IDLE) && req_valid && !flush;
  assign step  = ((state == MUL) || (state == DIV)) && !flush;
  assign stall = (req_valid && (state == IDLE)) ||
                 ((state != IDLE) && !((state == DONE) && result_ready));

  muldiv_datapath u_datapath (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .step           (step),
    .funct3         (funct3),
    .rs1            (read_data1),
    .rs2            (read_data2),
    .special        (special),
    .special_result (special_result),
    .fix_result     (fix_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      result_valid  <= 1'b0;
      muldiv_result <= '0;
    end else if (flush && (state != IDLE)) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            req_ready <= 1'b0;
            if (special) begin
              state         <= DONE;
              muldiv_result <= special_result;
              result_valid  <= 1'b1;
            end else begin
              state <= funct3[2] ? DIV : MUL;
              cnt   <= CNT_W'(XLEN - 1);
            end
          end
        end
        MUL, DIV: begin
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          state         <= DONE;
          muldiv_result <= fix_result;
          result_valid  <= 1'b1;
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            req_ready    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: hand-computed RV32M results, latency,
// stall/handshake behaviour, backpressure, flush and async reset.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] muldiv_result;
  logic        stall;

  int n_vec;
  int n_bad;

  alu_muldiv_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .funct3        (funct3),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .flush         (flush),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .muldiv_result (muldiv_result),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request before edge 0; lat counts edges after edge 0 until result_valid.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid  = 1'b1;
    funct3     = f3;
    read_data1 = a;
    read_data2 = b;
    #1;
    check("stall_cycle0", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    read_data1 = 32'h0;
    read_data2 = 32'h0;
  endtask

  task automatic wait_valid(output int lat, output logic stall_ok);
    lat      = 0;
    stall_ok = 1'b1;
    while (!result_valid && lat < 60) begin
      if (!stall) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic stall_ok;
    issue(f3, a, b);
    wait_valid(lat, stall_ok);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, muldiv_result, exp);
    check({tag, "_stall_busy"}, {31'b0, stall_ok}, 32'd1);
    check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {30'b0, req_ready, result_valid}, 32'd2);
  endtask

  initial begin
    int   lat;
    logic stall_ok;
    logic [31:0] held;
    n_vec        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    funct3       = 3'b000;
    read_data1   = 32'h0;
    read_data2   = 32'h0;
    flush        = 1'b0;
    result_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_result", muldiv_result, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;

    run_op("mul",     3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",   3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu0",   3'b101, 32'h00001234, 32'h0,        32'hFFFFFFFF, 0);
    run_op("remu0",   3'b111, 32'h00001234, 32'h0,        32'h00001234, 0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

    // Backpressure: hold result_ready low for 5 cycles in DONE.
    result_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7);
    wait_valid(lat, stall_ok);
    check("bp_lat", lat, 33);
    held = muldiv_result;
    check("bp_res", held, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {29'b0, result_valid, stall, req_ready}, 32'd6);
      check("bp_stable", muldiv_result, 32'd14);
    end
    result_ready = 1'b1;
    #1;
    check("bp_release_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_idle", {30'b0, req_ready, result_valid}, 32'd2);

    // Flush asserted during cycle 10 of a divide.
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", {30'b0, req_ready, result_valid}, 32'd2);
    check("flush_stall", {31'b0, stall}, 32'd0);
    wait_valid(lat, stall_ok);
    check("flush_no_result", lat, 60);

    // Flush in IDLE suppresses a simultaneous request.
    @(negedge clk);
    req_valid = 1'b1;
    funct3    = 3'b000;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_idle_reject", {31'b0, req_ready}, 32'd1);

    // Asynchronous reset in the middle of a multiply.
    issue(3'b000, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", {29'b0, req_ready, result_valid, stall}, 32'd4);
    check("arst_result", muldiv_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_mul", 3'b000, 32'd5, 32'd6, 32'd30, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
